alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter_pkg.sv | 17 +
 rtl/alu.sv | 31 +++
 rtl/alu_share_arbiter_rr_grant.sv | 35 +++
 rtl/alu_share_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU op codes and FSM states.
package alu_share_arbiter_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU of the multi-cycle core; unused op codes return an alternating-bit pattern.
module alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Z
);

    localparam logic [WIDTH-1:0] DEFAULT_RES = WIDTH'({((WIDTH + 1) / 2){2'b01}});

    always_comb begin
        ALUResult = DEFAULT_RES;
        case (ALUControl)
            ALU_ADD: ALUResult = a + b;
            ALU_SUB: ALUResult = a - b;
            ALU_AND: ALUResult = a & b;
            ALU_XOR: ALUResult = a ^ b;
            ALU_SLT: ALUResult = {{(WIDTH - 1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_OR:  ALUResult = a | b;
            default: ALUResult = DEFAULT_RES;
        endcase
    end

    assign Z = (ALUResult == '0);

endmodule

// File: rtl/alu_share_arbiter_rr_grant.sv
// Round-robin picker: the first valid requester strictly after last_grant, wrapping around.
module rr_grant #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic found;

    // Two passes: indices above last_grant first, then the wrapped-around low indices.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && valid[i] && (ID_W'(i) > last_grant)) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && valid[i] && (ID_W'(i) <= last_grant)) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NUM_REQ requesters with round-robin grants and a registered,
// ID-tagged response channel.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]     req_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_zero
);

    state_t             state, state_next;
    logic [ID_W-1:0]    last_grant, hold_id, grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               any_valid, grant_en, accept;
    logic [WIDTH-1:0]   hold_a, hold_b, sel_a, sel_b, alu_result;
    logic [2:0]         hold_op, sel_op;
    logic               alu_zero;

    assign any_valid = |req_valid;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_grant (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // A grant may be issued from IDLE, or from RESP in the same cycle the response is consumed.
    always_comb begin
        grant_en   = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                grant_en = 1'b1;
                if (any_valid) state_next = EXEC;
            end
            EXEC: state_next = RESP;
            RESP: begin
                grant_en = rsp_ready;
                if (rsp_ready) state_next = any_valid ? EXEC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept    = grant_en & any_valid;
    assign req_ready = grant_en ? grant : '0;

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
                sel_op = req_op[i*3 +: 3];
            end
        end
    end

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a          (hold_a),
        .b          (hold_b),
        .ALUControl (hold_op),
        .ALUResult  (alu_result),
        .Z          (alu_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // last_grant resets to the top index so requester 0 wins the first arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            hold_a     <= '0;
            hold_b     <= '0;
            hold_op    <= '0;
            hold_id    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            if (accept) begin
                hold_a     <= sel_a;
                hold_b     <= sel_b;
                hold_op    <= sel_op;
                hold_id    <= grant_idx;
                last_grant <= grant_idx;
            end
            if (state == EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= hold_id;
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with hand-computed expected responses.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [95:0] req_a;
    logic [95:0] req_b;
    logic [8:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero;

    int errorCount = 0;
    int checkCount = 0;

    alu_share_arbiter #(
        .WIDTH   (32),
        .NUM_REQ (3),
        .ID_W    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic v, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] op);
        req_valid[idx]       = v;
        req_a[idx*32 +: 32]  = a;
        req_b[idx*32 +: 32]  = b;
        req_op[idx*3 +: 3]   = op;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRsp(input string tag, input logic [31:0] res, input logic z, input logic [1:0] id);
        checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({tag, "_result"}, rsp_result, res);
        checkOutput({tag, "_zero"}, 32'(rsp_zero), 32'(z));
        checkOutput({tag, "_id"}, 32'(rsp_id), 32'(id));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expId;
        logic [31:0] expRes [3];
        expRes[0] = 32'd13;
        expRes[1] = 32'd7;
        expRes[2] = 32'd9;

        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        #2;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("rst_rsp_result", rsp_result, 32'd0);
        checkOutput("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        tick();
        reset = 1'b0;

        $display("[TB] single add from requester 0");
        applyStimulus(0, 1'b1, 32'd5, 32'd7, ALU_ADD);
        #1 checkOutput("t1_grant", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        #1 checkOutput("t1_exec_ready", 32'(req_ready), 32'd0);
        checkOutput("t1_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        checkRsp("t1", 32'd12, 1'b0, 2'd0);
        rsp_ready = 1'b1;
        tick();
        checkOutput("t1_drop", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        $display("[TB] round-robin with all requesters valid");
        reset = 1'b1;
        #1 reset = 1'b0;
        applyStimulus(0, 1'b1, 32'd10, 32'd3, ALU_ADD);
        applyStimulus(1, 1'b1, 32'd10, 32'd3, ALU_SUB);
        applyStimulus(2, 1'b1, 32'd10, 32'd3, ALU_XOR);
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            expId = k % 3;
            #1 checkOutput($sformatf("rr%0d_grant", k), 32'(req_ready), 32'd1 << expId);
            tick();
            checkOutput($sformatf("rr%0d_exec_valid", k), 32'(rsp_valid), 32'd0);
            tick();
            checkRsp($sformatf("rr%0d", k), expRes[expId], 1'b0, 2'(expId));
        end
        req_valid = '0;
        tick();
        checkOutput("rr_idle", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        $display("[TB] response held under backpressure");
        applyStimulus(1, 1'b1, 32'd9, 32'd9, ALU_SUB);
        #1 checkOutput("bp_grant", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        applyStimulus(0, 1'b1, 32'd1, 32'd2, ALU_ADD);
        applyStimulus(2, 1'b1, 32'd1, 32'd2, ALU_OR);
        #1 checkOutput("bp_exec_ready", 32'(req_ready), 32'd0);
        tick();
        for (int c = 0; c < 5; c++) begin
            checkRsp($sformatf("bp%0d", c), 32'd0, 1'b1, 2'd1);
            checkOutput($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        checkOutput("bp_drop", 32'(rsp_valid), 32'd0);

        $display("[TB] slt then default op from requester 2");
        applyStimulus(2, 1'b1, 32'd3, 32'd8, ALU_SLT);
        #1 checkOutput("slt_grant", 32'(req_ready), 32'b100);
        tick();
        req_valid = '0;
        tick();
        checkRsp("slt", 32'd1, 1'b0, 2'd2);
        applyStimulus(2, 1'b1, 32'd3, 32'd8, 3'b111);
        #1 checkOutput("def_grant", 32'(req_ready), 32'b100);
        tick();
        req_valid = '0;
        checkOutput("def_exec_valid", 32'(rsp_valid), 32'd0);
        tick();
        checkRsp("def", 32'h5555_5555, 1'b0, 2'd2);
        tick();
        checkOutput("def_drop", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        $display("[TB] reset while an add is executing");
        applyStimulus(1, 1'b1, 32'd4, 32'd4, ALU_ADD);
        #1 checkOutput("mr_grant", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        #2 reset = 1'b1;
        #1;
        checkOutput("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mr_rsp_result", rsp_result, 32'd0);
        checkOutput("mr_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("mr_req_ready", 32'(req_ready), 32'd0);
        #1 reset = 1'b0;
        tick();
        tick();
        checkOutput("mr_no_rsp", 32'(rsp_valid), 32'd0);
        applyStimulus(1, 1'b1, 32'd6, 32'd2, ALU_SUB);
        applyStimulus(2, 1'b1, 32'd6, 32'd2, ALU_AND);
        #1 checkOutput("mr_regrant", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        tick();
        checkRsp("mr", 32'd4, 1'b0, 2'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        $display("[TB] requester 0 withdraws before grant");
        applyStimulus(2, 1'b1, 32'h0000_00F0, 32'h0000_000F, ALU_OR);
        #1 checkOutput("wd_first_grant", 32'(req_ready), 32'b100);
        tick();
        req_valid = '0;
        applyStimulus(0, 1'b1, 32'd1, 32'd1, ALU_ADD);
        applyStimulus(1, 1'b1, 32'h0000_00FF, 32'h0000_000F, ALU_AND);
        #1 checkOutput("wd_exec_ready", 32'(req_ready), 32'd0);
        tick();
        checkRsp("wd_or", 32'h0000_00FF, 1'b0, 2'd2);
        checkOutput("wd_resp_ready", 32'(req_ready), 32'd0);
        req_valid[0] = 1'b0;
        rsp_ready = 1'b1;
        #1 checkOutput("wd_grant", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        #1 checkOutput("wd_exec2_ready", 32'(req_ready), 32'd0);
        tick();
        checkRsp("wd_and", 32'h0000_000F, 1'b0, 2'd1);
        tick();
        checkOutput("wd_idle_valid", 32'(rsp_valid), 32'd0);
        checkOutput("wd_idle_ready", 32'(req_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
